// File: rtl/timing_sequencer_if.sv
// Control-unit side bundle of the run/halt/step timing sequencer: requests, strobes,
// the IR bus input, and the timing/decode/status outputs.
interface timing_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             clr_sc;
  logic             ld_ir;
  logic [7:0]       bus_in;

  logic [7:0]       T;
  logic [7:0]       D;
  logic             I;
  logic [7:0]       B;
  logic             busy;
  logic             halt_pend;
  logic [CNT_W-1:0] instr_cnt;
  logic             seq_err;

  // The front panel / control unit drives requests and strobes.
  modport master (
    output run_req, step_req, halt_req, clr_sc, ld_ir, bus_in,
    input  T, D, I, B, busy, halt_pend, instr_cnt, seq_err
  );

  // The sequencer consumes requests and produces timing and decode.
  modport slave (
    input  run_req, step_req, halt_req, clr_sc, ld_ir, bus_in,
    output T, D, I, B, busy, halt_pend, instr_cnt, seq_err
  );
endinterface

// File: rtl/timing_sequencer.sv
// Run/halt/step timing generator: owns the IR and the 3-bit sequence counter, and
// produces the one-hot T vector plus the D/I/B decode for the control unit.
module timing_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  timing_sequencer_if.slave sif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sc_q, sc_d;
  logic [7:0]       ir_q, ir_d;
  logic             halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             seq_err_q, seq_err_d;

  logic busy;
  logic boundary;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'd1 << idx;
  endfunction

  assign busy     = (state_q != IDLE);
  assign boundary = busy & sif.clr_sc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sc_q        <= 3'd0;
      ir_q        <= 8'd0;
      halt_pend_q <= 1'b0;
      instr_cnt_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      ir_q        <= ir_d;
      halt_pend_q <= halt_pend_d;
      instr_cnt_q <= instr_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    ir_d        = ir_q;
    halt_pend_d = halt_pend_q;
    instr_cnt_d = instr_cnt_q;
    seq_err_d   = seq_err_q;

    unique case (state_q)
      IDLE: begin
        // A halt in IDLE has nothing to stop; it also masks a simultaneous start.
        sc_d        = 3'd0;
        halt_pend_d = 1'b0;
        if (sif.halt_req) begin
          state_d = IDLE;
        end else if (sif.step_req) begin
          state_d = STEP;
        end else if (sif.run_req) begin
          state_d = RUN;
        end
      end

      RUN, STEP: begin
        sc_d = sif.clr_sc ? 3'd0 : sc_q + 3'd1;
        if (sif.ld_ir) begin
          ir_d = sif.bus_in;
        end
        // Running off the end of T7 means the control unit missed its clear.
        if ((sc_q == 3'd7) && !sif.clr_sc) begin
          seq_err_d = 1'b1;
        end

        if (boundary) begin
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
          if ((state_q == STEP) || halt_pend_q || sif.halt_req) begin
            state_d     = IDLE;
            halt_pend_d = 1'b0;
          end
        end else if (sif.halt_req) begin
          halt_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sc_d    = 3'd0;
      end
    endcase
  end

  // Decode is combinational from the registered IR and gated by busy, so an
  // asynchronous reset clears it without waiting for a clock.
  always_comb begin
    sif.T = 8'd0;
    sif.D = 8'd0;
    sif.I = 1'b0;
    sif.B = 8'd0;
    if (busy) begin
      sif.T = onehot8(sc_q);
      sif.D = onehot8(ir_q[6:4]);
      sif.I = ir_q[7];
      sif.B = {4'b0000, ir_q[3:0]};
    end
  end

  assign sif.busy      = busy;
  assign sif.halt_pend = halt_pend_q;
  assign sif.instr_cnt = instr_cnt_q;
  assign sif.seq_err   = seq_err_q;

  a_t_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sif.T));
  a_idle_sc  : assert property (@(posedge clk) disable iff (!rst_n) (!busy) |-> (sc_q == 3'd0));
  a_idle_hp  : assert property (@(posedge clk) disable iff (!rst_n) (!busy) |-> !halt_pend_q);

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: each driven cycle pushes the expected
// post-edge outputs; observations are popped and compared per scenario.
module tb_timing_sequencer;

  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;

  timing_sequencer_if #(.CNT_W(CNT_W)) sif ();

  timing_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       run;
    logic       step;
    logic       halt;
    logic       clr;
    logic       ld;
    logic [7:0] bus;
  } stim_t;

  typedef struct packed {
    logic [7:0]       t;
    logic [7:0]       d;
    logic [7:0]       b;
    logic             i;
    logic             busy;
    logic             hp;
    logic [CNT_W-1:0] cnt;
    logic             se;
  } exp_t;

  exp_t sbq[$];
  exp_t obsq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic stim_t st(input logic run, input logic step, input logic halt,
                               input logic clr, input logic ld, input logic [7:0] bus);
    st = '{run: run, step: step, halt: halt, clr: clr, ld: ld, bus: bus};
  endfunction

  function automatic exp_t ex(input logic [7:0] t, input logic [7:0] d, input logic [7:0] b,
                              input logic i, input logic hp, input logic [CNT_W-1:0] cnt,
                              input logic se);
    ex = '{t: t, d: d, b: b, i: i, busy: (t != 8'd0), hp: hp, cnt: cnt, se: se};
  endfunction

  function automatic exp_t observe();
    observe = '{t: sif.T, d: sif.D, b: sif.B, i: sif.I, busy: sif.busy,
                hp: sif.halt_pend, cnt: sif.instr_cnt, se: sif.seq_err};
  endfunction

  stim_t NONE;

  // Drive one cycle of stimulus, record the expectation, capture the DUT after the edge.
  task automatic cyc(input stim_t s, input exp_t e);
    sif.run_req  = s.run;
    sif.step_req = s.step;
    sif.halt_req = s.halt;
    sif.clr_sc   = s.clr;
    sif.ld_ir    = s.ld;
    sif.bus_in   = s.bus;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    obsq.push_back(observe());
    sif.run_req  = 1'b0;
    sif.step_req = 1'b0;
    sif.halt_req = 1'b0;
    sif.clr_sc   = 1'b0;
    sif.ld_ir    = 1'b0;
    sif.bus_in   = 8'h00;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int   n;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 0));
    cyc(st(0, 1, 0, 1, 1, 8'hFF), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 0));
    rst_n = 1'b1;
    cyc(NONE, ex(8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_run();
    exp_t e, o;
    int   n;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h01, 8'h01, 8'h00, 0, 0, 16'd0, 0));
    cyc(NONE,                     ex(8'h02, 8'h01, 8'h00, 0, 0, 16'd0, 0));
    cyc(st(0, 0, 0, 0, 1, 8'h12), ex(8'h04, 8'h02, 8'h02, 0, 0, 16'd0, 0));
    cyc(NONE,                     ex(8'h08, 8'h02, 8'h02, 0, 0, 16'd0, 0));
    cyc(NONE,                     ex(8'h10, 8'h02, 8'h02, 0, 0, 16'd0, 0));
    cyc(NONE,                     ex(8'h20, 8'h02, 8'h02, 0, 0, 16'd0, 0));
    cyc(st(0, 0, 0, 1, 0, 8'h00), ex(8'h01, 8'h02, 8'h02, 0, 0, 16'd1, 0));
    cyc(NONE,                     ex(8'h02, 8'h02, 8'h02, 0, 0, 16'd1, 0));
    cyc(st(0, 0, 0, 0, 1, 8'h12), ex(8'h04, 8'h02, 8'h02, 0, 0, 16'd1, 0));
    cyc(st(0, 0, 1, 1, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd2, 0));
    cyc(NONE,                     ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd2, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL run[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_step();
    exp_t e, o;
    int   n;
    cyc(st(0, 1, 0, 0, 0, 8'h00), ex(8'h01, 8'h02, 8'h02, 0, 0, 16'd2, 0));
    cyc(st(1, 1, 0, 0, 0, 8'h00), ex(8'h02, 8'h02, 8'h02, 0, 0, 16'd2, 0));
    cyc(st(0, 0, 0, 0, 1, 8'hF8), ex(8'h04, 8'h80, 8'h08, 1, 0, 16'd2, 0));
    cyc(NONE,                     ex(8'h08, 8'h80, 8'h08, 1, 0, 16'd2, 0));
    cyc(st(0, 0, 0, 1, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd3, 0));
    cyc(NONE,                     ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd3, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL step[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_halt();
    exp_t e, o;
    int   n;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h01, 8'h80, 8'h08, 1, 0, 16'd3, 0));
    cyc(NONE,                     ex(8'h02, 8'h80, 8'h08, 1, 0, 16'd3, 0));
    cyc(st(0, 0, 0, 0, 1, 8'h12), ex(8'h04, 8'h02, 8'h02, 0, 0, 16'd3, 0));
    cyc(st(0, 0, 1, 0, 0, 8'h00), ex(8'h08, 8'h02, 8'h02, 0, 1, 16'd3, 0));
    cyc(NONE,                     ex(8'h10, 8'h02, 8'h02, 0, 1, 16'd3, 0));
    cyc(st(0, 0, 0, 1, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    cyc(NONE,                     ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL halt[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_idle_priority();
    exp_t e, o;
    int   n;
    cyc(st(1, 0, 1, 0, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    cyc(st(0, 1, 1, 0, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    cyc(st(0, 0, 1, 0, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    cyc(NONE,                     ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd4, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL idle_prio[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_seq_err();
    exp_t e, o;
    int   n;
    logic [7:0] t;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h01, 8'h02, 8'h02, 0, 0, 16'd4, 0));
    t = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = t << 1;
      cyc(NONE, ex(t, 8'h02, 8'h02, 0, 0, 16'd4, 0));
    end
    cyc(NONE,                     ex(8'h01, 8'h02, 8'h02, 0, 0, 16'd4, 1));
    cyc(NONE,                     ex(8'h02, 8'h02, 8'h02, 0, 0, 16'd4, 1));
    cyc(st(0, 0, 1, 1, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd5, 1));
    cyc(NONE,                     ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd5, 1));
    // Only reset clears the sticky error.
    rst_n = 1'b0;
    sbq.push_back(ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd0, 0));
    #1;
    obsq.push_back(observe());
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL seq_err[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_cnt_wrap();
    exp_t e, o;
    int   n;
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h01, 8'h01, 8'h00, 0, 0, cnt, 0));
    // One-cycle instructions back to back: every cycle is a boundary at T0.
    for (int k = 0; k < 65535; k++) begin
      cnt = cnt + 1'b1;
      cyc(st(0, 0, 0, 1, 0, 8'h00), ex(8'h01, 8'h01, 8'h00, 0, 0, cnt, 0));
      if (k % 4096 == 4095 || k == 65534) begin
        n = 0;
        while (sbq.size() != 0) begin
          e = sbq.pop_front();
          o = obsq.pop_front();
          total++;
          if (o !== e) begin
            bad++;
            $display("FAIL cnt_fill[%0d] got=%h want=%h", k, o, e);
          end
          n++;
        end
      end
    end
    cyc(st(0, 0, 1, 1, 0, 8'h00), ex(8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL cnt_wrap[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, o;
    int   n;
    cyc(st(1, 0, 0, 0, 0, 8'h00), ex(8'h01, 8'h01, 8'h00, 0, 0, 16'd0, 0));
    cyc(st(0, 0, 0, 1, 0, 8'h00), ex(8'h01, 8'h01, 8'h00, 0, 0, 16'd1, 0));
    cyc(NONE,                     ex(8'h02, 8'h01, 8'h00, 0, 0, 16'd1, 0));
    cyc(st(0, 0, 0, 0, 1, 8'h12), ex(8'h04, 8'h02, 8'h02, 0, 0, 16'd1, 0));
    cyc(st(0, 0, 1, 0, 0, 8'h00), ex(8'h08, 8'h02, 8'h02, 0, 1, 16'd1, 0));
    // Mid-cycle, well away from any clock edge.
    #1 rst_n = 1'b0;
    sbq.push_back(ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd0, 0));
    #1;
    obsq.push_back(observe());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(NONE, ex(8'h00, 8'h00, 8'h00, 0, 0, 16'd0, 0));
    n = 0;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      o = obsq.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL async_reset[%0d] got=%h want=%h", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    NONE         = '0;
    sif.run_req  = 1'b0;
    sif.step_req = 1'b0;
    sif.halt_req = 1'b0;
    sif.clr_sc   = 1'b0;
    sif.ld_ir    = 1'b0;
    sif.bus_in   = 8'h00;
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_idle_priority();
    test_seq_err();
    test_cnt_wrap();
    test_async_reset();
    total++;
    if (obsq.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", obsq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Run/halt/step timing generator for the basic accumulator computer. Holds the instruction register and the 3-bit sequence counter. Drives the one-hot timing vector T, the opcode decode D, the indirect bit I and the register-reference field B into the control unit. Consumes the control unit's SC-clear and IR-load strobes, so it sets how many cycles each instruction takes and when the machine stops.

## Interface
- CNT_W, 16: width of the retired-instruction counter.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- run_req  in  1  pulse; start free-running execution.
- step_req  in  1  pulse; execute exactly one instruction.
- halt_req  in  1  pulse; stop at the next instruction boundary.
- clr_sc  in  1  SC-clear from the control unit; marks the last cycle of an instruction.
- ld_ir  in  1  IR load strobe from the control unit (asserted at T1).
- bus_in  in  8  common bus; source for the IR.
- T  out  8  one-hot timing, T[k] = (sc == k); all zero when not executing.
- D  out  8  one-hot decode of IR[6:4]; all zero when not executing.
- I  out  1  IR[7] when executing, else 0.
- B  out  8  {4'b0, IR[3:0]} when executing, else 0. B[3]=CLA, B[2]=CMA, B[1]=CIR, B[0]=CIL.
- busy  out  1  1 in RUN or STEP.
- halt_pend  out  1  a halt request is latched and waiting for a boundary.
- instr_cnt  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- seq_err  out  1  sticky; the sequence counter wrapped without clr_sc.

## Operation
- FSM states:
  - IDLE (reset state).
  - RUN: free-running.
  - STEP: single instruction.
- Registers:
  - sc[2:0]
  - ir[7:0]
  - halt_pend
  - instr_cnt
  - seq_err
- Reset (rst_n low, asynchronous): state=IDLE, sc=0, ir=0, halt_pend=0, instr_cnt=0, seq_err=0.
- Outputs during reset: T, D, B = 0; I, busy, halt_pend, seq_err = 0; instr_cnt = 0.
- IDLE:
  - sc is held at 0.
  - Request priority: halt_req > step_req > run_req.
  - halt_req in IDLE is discarded; halt_pend stays 0.
  - step_req → STEP; run_req → RUN. sc=0 in the first active cycle, so T0 appears one cycle after the request edge.
- RUN/STEP, every cycle:
  - If clr_sc: sc <= 0.
  - Otherwise: sc <= sc+1.
  - If ld_ir: ir <= bus_in.
- Instruction boundary = busy & clr_sc. At a boundary:
  - instr_cnt increments.
  - If STEP, or RUN with halt_pend (or halt_req in the same cycle): next state IDLE, halt_pend cleared. Otherwise stay in RUN.
- halt_req while busy and not at a boundary sets halt_pend. run_req and step_req while busy are ignored.
- Wrap error: sc==7 with clr_sc=0 sets seq_err.
  - sc wraps to 0 and execution continues.
  - The wrap is not a boundary and is not counted.
- D, I and B decode the registered ir. They are combinational from ir and state.

## Timing
- Request-to-T0 latency: 1 cycle.
- clr_sc sampled at edge k gives T0 in cycle k+1. There is no idle cycle between instructions in RUN.
- IR loaded at the T1 edge: D, I and B show the new instruction from T2 onward. During T0–T1 they show the previous instruction, which the control unit never uses then.
- Last instruction before IDLE: outputs go to 0 the cycle after the boundary edge.
- halt_req in the same cycle as a boundary takes effect at that boundary; halt_pend never becomes visible.
- instr_cnt updates at the boundary edge. It is visible one cycle later.
- Reset mid-instruction: immediate return to IDLE. The partial instruction is not counted.

## Test plan
- Reset, then run_req, with clr_sc at T5 and bus_in=8'h12 at T1:
  - T sequence 01,02,04,08,10,20,01.
  - D=8'h02 and I=0 from T2.
  - instr_cnt=1 after the first boundary.
- step_req with bus_in=8'hF8 (I=1, opcode 7), clr_sc at T3:
  - Exactly 4 active cycles, then IDLE with T=0.
  - instr_cnt=1; busy falls the cycle after the T3 edge.
- RUN, halt_req at T2, clr_sc at T4:
  - halt_pend=1 during T3–T4.
  - IDLE after the T4 edge; halt_pend=0; no further T0.
- RUN, never assert clr_sc:
  - seq_err=1 after the T7 edge; T returns to 01.
  - instr_cnt unchanged; seq_err stays 1 until rst_n.
- halt_req and run_req together in IDLE: stays IDLE, T=0, halt_pend=0.
- Preload instr_cnt to 16'hFFFF via repeated steps, then one more boundary: instr_cnt=0.
- rst_n low at T3 of RUN: T, D, busy and instr_cnt go to 0 immediately, without waiting for a clock edge.
